// File: rtl/demux_16_buf.sv
// Buffered 1:16 distributor. Words from one valid/ready source land in one of
// sixteen single-entry slots chosen by in_select. Each slot holds its word for
// its own consumer until that consumer acknowledges it.
module demux_16_buf #(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [3:0]            in_select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [16*WIDTH-1:0]   out_data,
  output logic [15:0]           out_valid,
  input  logic [15:0]           out_ack,
  output logic [4:0]            count_full
);

  logic        accept;
  logic [15:0] load;
  logic [15:0] consume;
  logic [4:0]  consume_count;
  logic [4:0]  count_next;

  // A slot can take a new word when it is empty or is being drained in the
  // same edge. Holding reset low blocks every transfer.
  assign in_ready = reset & (~out_valid[in_select] | out_ack[in_select]);
  assign accept   = in_valid & in_ready;
  assign consume  = out_ack & out_valid;

  // Decode the load strobe and count the acks that actually take a word.
  // The select is only looked at once a transfer is accepted, so an unknown
  // select while in_valid is low cannot reach any slot.
  always_comb begin
    load          = '0;
    consume_count = '0;
    if (accept) begin
      load[in_select] = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      consume_count = consume_count + {4'b0000, consume[i]};
    end
    // Modulo-32 arithmetic: the final value is always in 0..16, because a
    // write into a full bank needs a matching ack on the same slot.
    count_next = count_full + {4'b0000, accept} - consume_count;
  end

  // Occupancy count and per-slot full flags. A refill of a slot that is
  // being acked keeps its flag set and leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid  <= '0;
      count_full <= '0;
    end else begin
      out_valid  <= (out_valid & ~consume) | load;
      count_full <= count_next;
    end
  end

  // Slot data registers. Data is kept after consumption and only cleared by
  // reset, so a consumer may still look at the last word it took.
  for (genvar g = 0; g < 16; g++) begin : g_slot
    always_ff @(posedge clock) begin
      if (!reset) begin
        out_data[g*WIDTH +: WIDTH] <= '0;
      end else if (load[g]) begin
        out_data[g*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_demux_16_buf.sv
// Self-checking bench for demux_16_buf: directed scenarios followed by
// randomized traffic, all compared against a slot-level reference model.
module tb_demux_16_buf;
  localparam int WIDTH = 32;

  logic               clock;
  logic               reset;
  logic [WIDTH-1:0]   in_data;
  logic [3:0]         in_select;
  logic               in_valid;
  logic               in_ready;
  logic [16*WIDTH-1:0] out_data;
  logic [15:0]        out_valid;
  logic [15:0]        out_ack;
  logic [4:0]         count_full;

  int errors = 0;
  int checks = 0;

  // Reference model: one occupancy flag and one word per slot.
  bit          m_valid[16];
  logic [31:0] m_data[16];

  demux_16_buf #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .count_full (count_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] exp_valid();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [4:0] exp_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_valid[i]);
    return 5'(n);
  endfunction

  function automatic bit exp_ready();
    if (!reset) return 1'b0;
    return !m_valid[in_select] || out_ack[in_select];
  endfunction

  // Apply the behavioural rules to the model for the inputs now applied,
  // then clock the DUT and settle 1 ns past the edge.
  task automatic tick();
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_data[i]  = '0;
      end
    end else begin
      bit acc = 0;
      int s   = 0;
      if (in_valid) begin
        s   = int'(in_select);
        acc = !m_valid[s] || out_ack[s];
      end
      for (int i = 0; i < 16; i++) if (out_ack[i]) m_valid[i] = 0;
      if (acc) begin
        m_valid[s] = 1;
        m_data[s]  = in_data;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_select = '0;
    in_data   = '0;
    out_ack   = '0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_select = 4'd0;
    in_data   = $urandom;
    out_ack   = '0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: in_ready=%b expected 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 16'h0000 || count_full !== 5'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%h count=%0d data_nonzero=%b expected 0000/0/0",
               out_valid, count_full, |out_data);
    end
    reset = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_release: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_single_route();
    in_valid  = 1'b1;
    in_select = 4'd5;
    in_data   = 32'hDEADBEEF;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 16'h0020 || out_data[5*WIDTH +: WIDTH] !== 32'hDEADBEEF || count_full !== 5'd1) begin
      errors++;
      $display("FAIL single_route: valid=%h slot5=%h count=%0d expected 0020/deadbeef/1",
               out_valid, out_data[5*WIDTH +: WIDTH], count_full);
    end
    out_ack = 16'h0020;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 16'h0000 || count_full !== 5'd0 || out_data[5*WIDTH +: WIDTH] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_consume: valid=%h slot5=%h count=%0d expected 0000/deadbeef/0",
               out_valid, out_data[5*WIDTH +: WIDTH], count_full);
    end
  endtask

  task automatic test_back_pressure();
    in_valid  = 1'b1;
    in_select = 4'd3;
    in_data   = 32'h1;
    tick();
    in_data = 32'h2;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: in_ready=%b expected 0", in_ready);
    end
    tick();
    checks++;
    if (out_data[3*WIDTH +: WIDTH] !== 32'h1 || count_full !== 5'd1) begin
      errors++;
      $display("FAIL bp_hold: slot3=%h count=%0d expected 1/1", out_data[3*WIDTH +: WIDTH], count_full);
    end
    out_ack = 16'h0008;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_ack: in_ready=%b expected 1", in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_data[3*WIDTH +: WIDTH] !== 32'h2 || out_valid !== 16'h0008 || count_full !== 5'd1) begin
      errors++;
      $display("FAIL bp_refill: slot3=%h valid=%h count=%0d expected 2/0008/1",
               out_data[3*WIDTH +: WIDTH], out_valid, count_full);
    end
    out_ack = 16'h0008;
    tick();
    idle_inputs();
  endtask

  task automatic test_fill_all();
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_select = 4'(i);
      in_data   = 32'(i + 100);
      tick();
    end
    idle_inputs();
    checks++;
    if (count_full !== 5'd16 || out_valid !== 16'hFFFF) begin
      errors++;
      $display("FAIL fill_all: count=%0d valid=%h expected 16/ffff", count_full, out_valid);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_data[i*WIDTH +: WIDTH] !== 32'(i + 100)) begin
        errors++;
        $display("FAIL fill_data[%0d]: got %0d expected %0d", i, out_data[i*WIDTH +: WIDTH], i + 100);
      end
      in_select = 4'(i);
      in_valid  = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL fill_ready[%0d]: in_ready=%b expected 0", i, in_ready);
      end
    end
    idle_inputs();
    out_ack = 16'hFFFF;
    tick();
    idle_inputs();
    checks++;
    if (count_full !== 5'd0 || out_valid !== 16'h0000) begin
      errors++;
      $display("FAIL drain_all: count=%0d valid=%h expected 0/0000", count_full, out_valid);
    end
  endtask

  task automatic test_multi_ack();
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_select = 4'(i);
      in_data   = 32'(i + 7);
      tick();
    end
    in_select = 4'd9;
    in_data   = 32'h55;
    out_ack   = 16'h0003;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 16'h0204 || count_full !== 5'd2 || out_data[9*WIDTH +: WIDTH] !== 32'h55) begin
      errors++;
      $display("FAIL multi_ack: valid=%h count=%0d slot9=%h expected 0204/2/55",
               out_valid, count_full, out_data[9*WIDTH +: WIDTH]);
    end
    out_ack = 16'hFFFF;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      in_select = 4'(i);
      in_data   = 32'(i + 1);
      tick();
    end
    checks++;
    if (count_full !== 5'd7) begin
      errors++;
      $display("FAIL pre_reset_count: count=%0d expected 7", count_full);
    end
    reset     = 1'b0;
    in_select = 4'd10;
    in_data   = 32'hCAFE;
    tick();
    reset = 1'b1;
    idle_inputs();
    checks++;
    if (out_valid !== 16'h0000 || count_full !== 5'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%h count=%0d data_nonzero=%b expected 0000/0/0",
               out_valid, count_full, |out_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 63) != 0);
      in_valid = $urandom_range(0, 2) != 0;
      in_data  = $urandom;
      out_ack  = 16'($urandom & $urandom);
      if (in_valid) in_select = 4'($urandom_range(0, 15));
      else          in_select = 4'bxxxx;
      #1;
      if (in_valid) begin
        checks++;
        if (in_ready !== exp_ready()) begin
          errors++;
          $display("FAIL rand_ready cycle %0d: in_ready=%b expected %b", n, in_ready, exp_ready());
        end
      end
      tick();
      checks++;
      if (out_valid !== exp_valid() || count_full !== exp_count()) begin
        errors++;
        $display("FAIL rand_state cycle %0d: valid=%h count=%0d expected %h/%0d",
                 n, out_valid, count_full, exp_valid(), exp_count());
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (out_data[i*WIDTH +: WIDTH] !== m_data[i]) begin
          errors++;
          $display("FAIL rand_data cycle %0d slot %0d: got %h expected %h",
                   n, i, out_data[i*WIDTH +: WIDTH], m_data[i]);
        end
      end
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_data[i]  = '0;
    end
    test_reset();
    test_single_route();
    test_back_pressure();
    test_fill_all();
    test_multi_ack();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
